// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: APB3/APB4 slave register bank.
// NUM_REGS registers of DATA_WIDTH bits. Optional wait states (WAIT_CYCLES),
// read-only registers (RO_MASK) that return hw_status, error responses for
// out-of-range, misaligned and read-only writes, and protocol-abort detection.
// Optional macro APB_WSTRB_EN adds the PSTRB byte-lane write strobe port.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for a setup phase (sel=1, enable=0)
// ST_WAIT | access phase, inserting wait states, cnt counts down to 1
// ST_RESP | ready, slave_error and rdata valid; write commits at exit
module apb_slave_regbank #(
  parameter int                ADDR_WIDTH  = 16,
  parameter int                DATA_WIDTH  = 32,
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sel,
  input  logic                           enable,
  input  logic                           write,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          wdata,
`ifdef APB_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]        strb,
`endif
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           ready,
  output logic                           slave_error,
  output logic                           other_error,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic latch_en;
  logic go_resp;
  logic abort;
  logic commit;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  cur_write;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  hit;
  logic                  ro_hit;
  logic                  misaligned;
  logic                  err_c;
  logic [DATA_WIDTH-1:0] rd_c;

  // State register and wait-state down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; any loss of sel/enable after setup is an abort.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    go_resp  = 1'b0;
    abort    = 1'b0;
    commit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel && !enable) begin
          latch_en = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            go_resp = 1'b1;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = ST_WAIT;
          end
        end else if (sel && enable) begin
          abort = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!(sel && enable)) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd1) begin
          go_resp = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (sel && enable) begin
          commit = write_q && !slave_error;
        end else begin
          abort = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // With no wait states the response is decided on the same edge that
  // latches the setup phase, so decode from the live bus in IDLE.
  always_comb begin
    cur_addr  = (state_q == ST_IDLE) ? addr  : addr_q;
    cur_write = (state_q == ST_IDLE) ? write : write_q;
  end

`ifdef APB_WSTRB_EN
  logic [NB-1:0] cur_strb;
  always_comb cur_strb = (state_q == ST_IDLE) ? strb : strb_q;
`endif

  // Address decode, error classification and read mux for the response.
  always_comb begin
    cur_idx    = cur_addr >> LSB;
    misaligned = (cur_addr & ADDR_WIDTH'(NB - 1)) != '0;
    hit        = 1'b0;
    ro_hit     = 1'b0;
    rd_c       = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cur_idx == ADDR_WIDTH'(i)) begin
        hit    = 1'b1;
        ro_hit = RO_MASK[i];
        rd_c   = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
    err_c = !hit || misaligned || (cur_write && ro_hit);
`ifdef APB_WSTRB_EN
    err_c = err_c || (!cur_write && (cur_strb != '0));
`endif
  end

  // Transfer capture at the setup edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (latch_en) begin
      addr_q  <= addr;
      write_q <= write;
      wdata_q <= wdata;
`ifdef APB_WSTRB_EN
      strb_q  <= strb;
`else
      strb_q  <= '1;
`endif
    end
  end

  // Registered response outputs; valid only during the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready       <= 1'b0;
      slave_error <= 1'b0;
      rdata       <= '0;
      other_error <= 1'b0;
    end else begin
      ready       <= go_resp;
      slave_error <= go_resp && err_c;
      rdata       <= (go_resp && !err_c && !cur_write) ? rd_c : '0;
      other_error <= abort;
    end
  end

  always_comb wr_idx = addr_q >> LSB;

  // Register file; writes land byte-lane by byte-lane at the end of RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == ADDR_WIDTH'(i) && !RO_MASK[i]) begin
          for (int b = 0; b < NB; b++) begin
            if (strb_q[b]) begin
              regs[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Read-only slots are never written, but force them to zero explicitly.
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
    end
  end

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
- Parametrised APB3/APB4 slave that replaces the fixed-width testbench slave connection with a synthesisable register bank.
- NUM_REGS registers, each DATA_WIDTH wide, accessed over APB.
- Adds a programmable wait-state count, address/alignment/read-only error responses, and protocol-abort detection.
- Sits behind the APB master/decoder; its register contents drive the peripheral, and selected registers return hardware status.

Parameters:
- ADDR_WIDTH, 16, APB address width.
- DATA_WIDTH, 32, APB data width; must be 8, 16 or 32.
- NUM_REGS, 8, number of registers; range 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- WAIT_CYCLES, 0, extra access-phase cycles inserted before ready (0..15).
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, reading hw_status slice i.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sel  in  1  PSEL
- enable  in  1  PENABLE
- write  in  1  PWRITE
- addr  in  ADDR_WIDTH  PADDR, byte address
- wdata  in  DATA_WIDTH  PWDATA
- rdata  out  DATA_WIDTH  PRDATA
- ready  out  1  PREADY
- slave_error  out  1  PSLVERR
- other_error  out  1  one-cycle pulse on protocol abort
- hw_status  in  NUM_REGS*DATA_WIDTH  read value for RO registers, register i at slice i
- reg_out  out  NUM_REGS*DATA_WIDTH  current contents of the RW registers; RO slices read 0

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; rdata, ready, slave_error, other_error=0; all RW registers=0.
- Register index = addr >> log2(DATA_WIDTH/8). An access is aligned when the addr low log2(DATA_WIDTH/8) bits are 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A clock edge that samples sel=1, enable=0 latches addr, write and wdata.
  - If WAIT_CYCLES=0: go to RESP. Otherwise load cnt=WAIT_CYCLES and go to WAIT.
- WAIT:
  - Requires sel=1 and enable=1 each cycle; cnt decrements.
  - When cnt reaches 1 (at the next edge): go to RESP.
- RESP:
  - ready=1 for exactly one cycle. slave_error and rdata are valid in that same cycle.
  - The write commits at the edge ending RESP.
  - Next state is IDLE; ready, slave_error and rdata return to 0.
- Latency: ready is high in access cycle WAIT_CYCLES+1, i.e. the transfer takes 2+WAIT_CYCLES cycles including setup.
- Error response (slave_error=1 with ready):
  - Conditions: index >= NUM_REGS, unaligned address, or a write to an RO register.
  - On error: no register changes; rdata=0.
- Reads:
  - RW register: returns register contents.
  - RO register: returns the hw_status slice sampled in the cycle ready is set.
- Protocol abort:
  - Triggered when sel=0 or enable=0 is seen in WAIT or RESP.
  - Response: return to IDLE; no write; ready=0; other_error pulses high for one cycle.
- Back-to-back transfers:
  - A new setup phase in the cycle after RESP is accepted. No idle cycle is required.
- sel=1 with enable=1 while in IDLE (no setup phase): ignored, and other_error pulses.
- Reset mid-transfer: everything returns to reset state immediately; the write does not commit.

Optional Feature:
- Macro: APB_WSTRB_EN.
- Defined:
  - Adds port strb, input, DATA_WIDTH/8 bits (PSTRB).
  - Only byte lanes whose strb bit is 1 are written; strb=0 on a write is a legal no-op with no error.
  - A read with strb not equal to 0 returns slave_error=1 and rdata=0.
- Undefined:
  - No strb port; every write updates the full word.

Test Plan:
- Reset then read all registers, WAIT_CYCLES=0 -> each read completes in 2 cycles, rdata=0, slave_error=0.
- WAIT_CYCLES=3: write 0xDEADBEEF to addr 0x4, then read addr 0x4 -> ready high in the 4th access cycle; reg_out slice 1 = 0xDEADBEEF; rdata=0xDEADBEEF.
- Error cases:
  - Write to addr 0x20 with NUM_REGS=8 -> slave_error=1, no register change.
  - Write to addr 0x2 -> slave_error=1, no register change.
  - Write to RO register 2 (RO_MASK=0x04) -> slave_error=1; a subsequent read returns the hw_status slice 2 value 0x12345678.
- Drop sel during WAIT (WAIT_CYCLES=2) -> other_error pulses for 1 cycle; target register unchanged; the next transfer completes normally.
- Assert rst_n low during WAIT of a write to addr 0x0 -> ready=0; register 0 stays 0 after reset is released.
- APB_WSTRB_EN defined:
  - Register 0 = 0xAABBCCDD; write wdata=0x11223344 with strb=0b0101 -> register 0 = 0xAA22CC44.
  - Read with strb=0b0001 -> slave_error=1, rdata=0.
